// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/bubble/flush controller with stall watchdog
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int STAGES    = 6,
    parameter int AW        = 32,
    parameter int FLUSH_CYC = 1,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req,
    input  logic              flush_req,
    input  logic [AW-1:0]     flush_pc,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic              flush,
    output logic [AW-1:0]     new_pc,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int RW  = $clog2(TIMEOUT);
    localparam logic [FCW-1:0] FC_LOAD = FCW'(FLUSH_CYC - 1);
    localparam logic [RW-1:0]  RUN_MAX = RW'(TIMEOUT - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [RW-1:0]   run_q, run_d;
    logic            to_q, to_d;
    logic            acc;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush_req) state_d = FLUSH;
            FLUSH:   if (fcnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A stall at stage k must freeze every earlier register as well.
    always_comb begin
        flush  = (state_q == FLUSH);
        stall  = '0;
        bubble = '0;
        acc    = 1'b0;
        if (!rst && state_q == IDLE) begin
            for (int i = STAGES - 1; i >= 0; i--) begin
                acc      = acc | stall_req[i];
                stall[i] = acc;
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            bubble[i] = stall[i-1] & ~stall[i];
        end
    end

    always_comb begin
        pc_d   = pc_q;
        fcnt_d = fcnt_q;
        run_d  = run_q;
        to_d   = to_q;
        if (state_q == FLUSH) begin
            run_d = '0;
            if (fcnt_q != '0) fcnt_d = fcnt_q - 1'b1;
        end else begin
            if (|stall_req) begin
                if (run_q == RUN_MAX) to_d  = 1'b1;
                else                  run_d = run_q + 1'b1;
            end else begin
                run_d = '0;
            end
            if (flush_req) begin
                pc_d   = flush_pc;
                fcnt_d = FC_LOAD;
                run_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            fcnt_q <= '0;
            run_q  <= '0;
            to_q   <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            fcnt_q <= fcnt_d;
            run_q  <= run_d;
            to_q   <= to_d;
        end
    end

    assign new_pc        = pc_q;
    assign stall_timeout = to_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] sc_q, sc_d, fc_q, fc_d;

    always_comb begin
        sc_d = sc_q;
        fc_d = fc_q;
        if (stall[0] && sc_q != '1) sc_d = sc_q + 1'b1;
        if (state_q == IDLE && flush_req && fc_q != '1) fc_d = fc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q <= '0;
            fc_q <= '0;
        end else begin
            sc_q <= sc_d;
            fc_q <= fc_d;
        end
    end

    assign stall_cycles = sc_q;
    assign flush_count  = fc_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl (FLUSH_CYC=3, TIMEOUT=4, CNT_W=4)
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_req;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall, bubble;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [3:0]  stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;
    int vec    = 0;

    typedef struct {
        int          id;
        logic [5:0]  stall;
        logic [5:0]  bubble;
        logic        flush;
        logic [31:0] pc;
        logic        to;
        logic [3:0]  sc;
        logic [3:0]  fc;
    } exp_t;

    exp_t sb[$];

    pipe_ctrl #(
        .STAGES(6), .AW(32), .FLUSH_CYC(3), .TIMEOUT(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
        .flush_pc(flush_pc), .stall(stall), .bubble(bubble), .flush(flush),
        .new_pc(new_pc), .stall_timeout(stall_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", nm, id, act, want);
        end
    endtask

    // Monitor: compares the DUT's outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("stall",   e.id, {26'd0, stall},         {26'd0, e.stall});
            check("bubble",  e.id, {26'd0, bubble},        {26'd0, e.bubble});
            check("flush",   e.id, {31'd0, flush},         {31'd0, e.flush});
            check("new_pc",  e.id, new_pc,                 e.pc);
            check("timeout", e.id, {31'd0, stall_timeout}, {31'd0, e.to});
            check("stall_cycles", e.id, {28'd0, stall_cycles}, {28'd0, e.sc});
            check("flush_count",  e.id, {28'd0, flush_count},  {28'd0, e.fc});
        end
    end

    task automatic step(input logic r, input logic [5:0] sr, input logic fr, input logic [31:0] fpc,
                        input logic [5:0] es, input logic [5:0] eb, input logic ef,
                        input logic [31:0] epc, input logic eto, input logic [3:0] esc,
                        input logic [3:0] efc);
        exp_t e;
        rst       = r;
        stall_req = sr;
        flush_req = fr;
        flush_pc  = fpc;
        e.id = vec; e.stall = es; e.bubble = eb; e.flush = ef;
        e.pc = epc; e.to = eto; e.sc = esc; e.fc = efc;
`ifndef PIPE_CTRL_PERF_EN
        e.sc = 4'd0;
        e.fc = 4'd0;
`endif
        sb.push_back(e);
        vec++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_req = '0; flush_req = 1'b0; flush_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        //   rst sreq       fr  fpc      stall      bubble     fl pc      to sc  fc
        step(1, 6'b000100, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h0,  0, 0,  0);
        step(0, 6'b000100, 0, 32'h0,   6'b000111, 6'b001000, 0, 32'h0,  0, 0,  0);
        step(0, 6'b000100, 0, 32'h0,   6'b000111, 6'b001000, 0, 32'h0,  0, 1,  0);
        step(0, 6'b000100, 0, 32'h0,   6'b000111, 6'b001000, 0, 32'h0,  0, 2,  0);
        step(0, 6'b000000, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h0,  0, 3,  0);
        step(0, 6'b001010, 0, 32'h0,   6'b001111, 6'b010000, 0, 32'h0,  0, 3,  0);
        step(0, 6'b000000, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h0,  0, 4,  0);
        // flush accepted with a pending stall; second request inside the flush is dropped
        step(0, 6'b000011, 1, 32'h40,  6'b000011, 6'b000100, 0, 32'h0,  0, 4,  0);
        step(0, 6'b000011, 0, 32'h0,   6'b000000, 6'b000000, 1, 32'h40, 0, 5,  1);
        step(0, 6'b000011, 1, 32'h80,  6'b000000, 6'b000000, 1, 32'h40, 0, 5,  1);
        step(0, 6'b000011, 0, 32'h0,   6'b000000, 6'b000000, 1, 32'h40, 0, 5,  1);
        step(0, 6'b000011, 0, 32'h0,   6'b000011, 6'b000100, 0, 32'h40, 0, 5,  1);
        step(0, 6'b000000, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h40, 0, 6,  1);
        // watchdog: fires after the 4th consecutive stalled cycle, sticky until rst
        step(0, 6'b000001, 0, 32'h0,   6'b000001, 6'b000010, 0, 32'h40, 0, 6,  1);
        step(0, 6'b000001, 0, 32'h0,   6'b000001, 6'b000010, 0, 32'h40, 0, 7,  1);
        step(0, 6'b000001, 0, 32'h0,   6'b000001, 6'b000010, 0, 32'h40, 0, 8,  1);
        step(0, 6'b000001, 0, 32'h0,   6'b000001, 6'b000010, 0, 32'h40, 0, 9,  1);
        step(0, 6'b000001, 0, 32'h0,   6'b000001, 6'b000010, 0, 32'h40, 1, 10, 1);
        step(0, 6'b000000, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h40, 1, 11, 1);
        step(0, 6'b000000, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h40, 1, 11, 1);
        step(1, 6'b000000, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h40, 1, 11, 1);
        step(0, 6'b000000, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h0,  0, 0,  0);
        // 20 stalled cycles: stall_cycles saturates at 15
        for (int j = 0; j < 20; j++) begin
            step(0, 6'b000001, 0, 32'h0, 6'b000001, 6'b000010, 0, 32'h0,
                 (j >= 4), (j > 15) ? 4'd15 : 4'(j), 0);
        end
        step(0, 6'b000000, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h0,  1, 15, 0);
        // reset in the middle of a flush aborts it
        step(0, 6'b000000, 1, 32'h100, 6'b000000, 6'b000000, 0, 32'h0,  1, 15, 0);
        step(1, 6'b000111, 0, 32'h0,   6'b000000, 6'b000000, 1, 32'h100, 1, 15, 1);
        step(0, 6'b000000, 0, 32'h0,   6'b000000, 6'b000000, 0, 32'h0,  0, 0,  0);
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
